// File: rtl/run_ctrl_pkg.sv
// Shared types, constants and the speed-to-divider mapping for run_ctrl.
package run_ctrl_pkg;

  typedef logic [1:0] speed_t;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } state_t;

  localparam speed_t      SPEED_MAX       = 2'd3;
  localparam int unsigned SPEED_DIV_SHIFT = 2;

  // Clock cycles per cpu_en at a given speed; the top speed advances every cycle.
  function automatic int unsigned div_for_speed(speed_t spd, int unsigned base);
    if (spd == SPEED_MAX) begin
      return 32'd1;
    end
    return base >> (SPEED_DIV_SHIFT * 32'(spd));
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, level debounce, one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Synchronize, accept a new level after DEBOUNCE_CYCLES disagreeing samples, pulse on rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run/pause and speed control producing the core's cpu_en clock-enable.
// Optional single-step button enabled by defining RUN_CTRL_STEP_EN.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BASE_DIV        = 100_000_000
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   btnU,
  input  logic   btnC,
`ifdef RUN_CTRL_STEP_EN
  input  logic   btnR,
  output logic   press_r,
`endif
  output logic   cpu_en,
  output logic   paused,
  output speed_t speed,
  output logic   press_u,
  output logic   press_c
);

  localparam int unsigned DIV_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

  state_t             state;
  state_t             state_next;
  speed_t             speed_next;
  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   div_next;
  logic [DIV_W-1:0]   div_last;
  logic [DIV_W-1:0]   div_last_next;
  logic               cpu_en_next;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_u (
    .clk   (clk),
    .rst   (rst),
    .raw   (btnU),
    .press (press_u)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_c (
    .clk   (clk),
    .rst   (rst),
    .raw   (btnC),
    .press (press_c)
  );

`ifdef RUN_CTRL_STEP_EN
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_r (
    .clk   (clk),
    .rst   (rst),
    .raw   (btnR),
    .press (press_r)
  );
`endif

  // Run/pause state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state, speed, divider and advance pulse.
  always_comb begin
    state_next    = state;
    speed_next    = speed;
    div_next      = div_cnt;
    cpu_en_next   = 1'b0;
    div_last      = DIV_W'(div_for_speed(speed, BASE_DIV) - 32'd1);
    div_last_next = div_last;

    if (press_c) begin
      state_next = (state == RUN) ? PAUSE : RUN;
    end
    if (press_u) begin
      speed_next    = speed + speed_t'(1);
      div_last_next = DIV_W'(div_for_speed(speed_next, BASE_DIV) - 32'd1);
    end

    // Speed change or resume restarts the period; counting only happens while running.
    if (press_u || (state == PAUSE && state_next == RUN)) begin
      div_next = '0;
    end else if (state_next == RUN) begin
      div_next = (div_cnt == div_last) ? '0 : div_cnt + DIV_W'(1);
    end

    cpu_en_next = (state_next == RUN) && (div_next == div_last_next);

`ifdef RUN_CTRL_STEP_EN
    if (state == PAUSE && press_r) begin
      cpu_en_next = 1'b1;
    end
`endif
  end

  // Registered outputs and divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      speed   <= '0;
      div_cnt <= '0;
      cpu_en  <= 1'b0;
      paused  <= 1'b0;
    end else begin
      speed   <= speed_next;
      div_cnt <= div_next;
      cpu_en  <= cpu_en_next;
      paused  <= (state_next == PAUSE);
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl (DEBOUNCE_CYCLES=4, BASE_DIV=64).
module tb_run_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned BDIV = 64;
  localparam int          HR   = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnU;
  logic       btnC;
  logic       btnR;
  logic       cpu_en;
  logic       paused;
  logic [1:0] speed;
  logic       press_u;
  logic       press_c;
  logic       press_r;

  always #5 clk = ~clk;

  run_ctrl #(.DEBOUNCE_CYCLES(DEB), .BASE_DIV(BDIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .btnU    (btnU),
    .btnC    (btnC),
`ifdef RUN_CTRL_STEP_EN
    .btnR    (btnR),
    .press_r (press_r),
`endif
    .cpu_en  (cpu_en),
    .paused  (paused),
    .speed   (speed),
    .press_u (press_u),
    .press_c (press_c)
  );

`ifndef RUN_CTRL_STEP_EN
  assign press_r = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Buttons: index 0 = U, 1 = C, 2 = R. Edges counted from the last reset.
  logic hist [3][HR];
  int   m_n;
  logic m_lvl [3];
  logic m_lvl_prev [3];
  logic m_press [3];
  int   m_last_flip [3];
  logic m_paused;
  logic m_cpu_en;
  int   m_speed;
  int   m_elapsed;

  // Debouncer input at edge n is the raw level two edges earlier (zero right after reset).
  function automatic logic m_sample(int b, int n);
    if (n >= 3) return hist[b][(n - 2) % HR];
    return 1'b0;
  endfunction

  function automatic int m_div(int spd);
    case (spd)
      0:       return 64;
      1:       return 16;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic void model_edge(logic r, logic u, logic c, logic s);
    logic raw [3];
    logic pu, pc, was_paused, clear, all_diff, newp;
`ifdef RUN_CTRL_STEP_EN
    logic pr;
`endif
    int   dv;
    raw = '{u, c, s};
    if (r) begin
      for (int b = 0; b < 3; b++) begin
        m_lvl[b] = 1'b0; m_lvl_prev[b] = 1'b0; m_press[b] = 1'b0; m_last_flip[b] = 0;
      end
      m_n = 0; m_paused = 1'b0; m_cpu_en = 1'b0; m_speed = 0; m_elapsed = 0;
      return;
    end
    pu = m_press[0];
    pc = m_press[1];
`ifdef RUN_CTRL_STEP_EN
    pr = m_press[2];
`endif
    was_paused = m_paused;
    clear = 1'b0;
    if (pc) begin
      m_paused = ~m_paused;
      if (!m_paused) clear = 1'b1;
    end
    if (pu) begin
      m_speed = (m_speed + 1) % 4;
      clear = 1'b1;
    end
    if (clear) m_elapsed = 0;
    else if (!m_paused) m_elapsed++;
    dv = m_div(m_speed);
    m_cpu_en = !m_paused && ((m_elapsed % dv) == dv - 1);
`ifdef RUN_CTRL_STEP_EN
    if (was_paused && pr) m_cpu_en = 1'b1;
`else
    if (was_paused && 1'b0) m_cpu_en = 1'b1;
`endif
    m_n++;
    for (int b = 0; b < 3; b++) begin
      hist[b][m_n % HR] = raw[b];
      newp = m_lvl[b] & ~m_lvl_prev[b];
      m_lvl_prev[b] = m_lvl[b];
      if (m_n - int'(DEB) >= m_last_flip[b]) begin
        all_diff = 1'b1;
        for (int k = 0; k < int'(DEB); k++)
          if (m_sample(b, m_n - k) == m_lvl[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[b] = ~m_lvl[b];
          m_last_flip[b] = m_n;
        end
      end
      m_press[b] = newp;
    end
  endfunction

  // One clock: drive, advance model, compare all outputs at the falling edge.
  task automatic tick(input logic r, input logic u, input logic c, input logic s);
    logic [6:0] act, exp;
    logic       exp_r;
    rst = r; btnU = u; btnC = c; btnR = s;
    @(posedge clk);
    model_edge(r, u, c, s);
    @(negedge clk);
`ifdef RUN_CTRL_STEP_EN
    exp_r = m_press[2];
`else
    exp_r = 1'b0;
`endif
    act = {cpu_en, paused, speed, press_u, press_c, press_r};
    exp = {m_cpu_en, m_paused, 2'(m_speed), m_press[0], m_press[1], exp_r};
    check("cycle_outputs", int'(act), int'(exp));
  endtask

  typedef struct {
    int en_cnt; int en_first; int en_second;
    int pu_cnt; int pu_first; int pc_cnt; int pr_cnt; int pr_first;
  } stats_t;

  task automatic run(input int n, input logic u, input logic c, input logic s, output stats_t st);
    st.en_cnt = 0; st.en_first = -1; st.en_second = -1;
    st.pu_cnt = 0; st.pu_first = -1; st.pc_cnt = 0; st.pr_cnt = 0; st.pr_first = -1;
    for (int i = 1; i <= n; i++) begin
      tick(1'b0, u, c, s);
      if (cpu_en) begin
        st.en_cnt++;
        if (st.en_first < 0) st.en_first = i;
        else if (st.en_second < 0) st.en_second = i;
      end
      if (press_u) begin
        st.pu_cnt++;
        if (st.pu_first < 0) st.pu_first = i;
      end
      if (press_c) st.pc_cnt++;
      if (press_r) begin
        st.pr_cnt++;
        if (st.pr_first < 0) st.pr_first = i;
      end
    end
  endtask

  typedef struct {
    logic u; logic c; int exp_speed; logic exp_paused; int exp_en_idle;
  } vec_t;

  vec_t   tbl [11];
  stats_t sa, sb;
  logic   ru, rc, rs, rr;
  int     hu, hc, hs;

  initial begin
    // Press sequences starting from speed 2, running. -1 = idle cpu_en count not checked.
    tbl[0]  = '{1'b1, 1'b0, 3, 1'b0, 12};
    tbl[1]  = '{1'b1, 1'b0, 0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0, 2, 1'b0, 3};
    tbl[4]  = '{1'b0, 1'b1, 2, 1'b1, 0};
    tbl[5]  = '{1'b1, 1'b0, 3, 1'b1, 0};
    tbl[6]  = '{1'b0, 1'b1, 3, 1'b0, 12};
    tbl[7]  = '{1'b1, 1'b1, 0, 1'b1, 0};
    tbl[8]  = '{1'b1, 1'b1, 1, 1'b0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1, 1'b1, 0};
    tbl[10] = '{1'b1, 1'b0, 2, 1'b1, 0};

    rst = 1'b1; btnU = 1'b0; btnC = 1'b0; btnR = 1'b0;
    @(negedge clk);

    // Reset and free-running speed 0.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_outputs", int'({cpu_en, paused, speed, press_u, press_c}), 0);
    run(130, 1'b0, 1'b0, 1'b0, sa);
    check("speed0_first_en", sa.en_first, 63);
    check("speed0_period", sa.en_second - sa.en_first, 64);
    check("speed0_en_count", sa.en_cnt, 2);

    // Speed button press: pulse 7 cycles after raw edge, then 16-cycle period.
    run(10, 1'b1, 1'b0, 1'b0, sa);
    run(40, 1'b0, 1'b0, 1'b0, sb);
    check("press_u_latency", sa.pu_first, 7);
    check("press_u_once", sa.pu_cnt + sb.pu_cnt, 1);
    check("speed_after_press", int'(speed), 1);
    check("speed1_first_en", sb.en_first, 13);
    check("speed1_period", sb.en_second - sb.en_first, 16);

    // Short glitch is rejected.
    run(2, 1'b1, 1'b0, 1'b0, sa);
    run(12, 1'b0, 1'b0, 1'b0, sb);
    check("glitch_no_press", sa.pu_cnt + sb.pu_cnt, 0);
    check("glitch_speed", int'(speed), 1);

    // Pause, change speed while paused, resume.
    run(10, 1'b0, 1'b1, 1'b0, sa);
    run(20, 1'b0, 1'b0, 1'b0, sb);
    check("paused_set", int'(paused), 1);
    check("paused_no_en", sb.en_cnt, 0);
    run(10, 1'b1, 1'b0, 1'b0, sa);
    run(12, 1'b0, 1'b0, 1'b0, sb);
    check("paused_speed", int'(speed), 2);
    check("paused_speed_no_en", sa.en_cnt + sb.en_cnt, 0);
    run(10, 1'b0, 1'b1, 1'b0, sa);
    run(20, 1'b0, 1'b0, 1'b0, sb);
    check("resume_paused", int'(paused), 0);
    check("resume_no_early_en", sa.en_cnt, 0);
    check("resume_first_en", sb.en_first, 1);
    check("resume_period", sb.en_second - sb.en_first, 4);

    // Table of press combinations.
    for (int i = 0; i < 11; i++) begin
      run(8, tbl[i].u, tbl[i].c, 1'b0, sa);
      run(12, 1'b0, 1'b0, 1'b0, sb);
      check($sformatf("tbl%0d_speed", i), int'(speed), tbl[i].exp_speed);
      check($sformatf("tbl%0d_paused", i), int'(paused), int'(tbl[i].exp_paused));
      check($sformatf("tbl%0d_press_u", i), sa.pu_cnt + sb.pu_cnt, int'(tbl[i].u));
      check($sformatf("tbl%0d_press_c", i), sa.pc_cnt + sb.pc_cnt, int'(tbl[i].c));
      if (tbl[i].exp_en_idle >= 0)
        check($sformatf("tbl%0d_idle_en", i), sb.en_cnt, tbl[i].exp_en_idle);
    end

    // Mid-operation reset at speed 2 while paused.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_reset_outputs", int'({cpu_en, paused, speed, press_u, press_c}), 0);
    run(140, 1'b0, 1'b0, 1'b0, sa);
    check("mid_reset_first_en", sa.en_first, 63);
    check("mid_reset_period", sa.en_second - sa.en_first, 64);

`ifdef RUN_CTRL_STEP_EN
    // Single step while paused.
    run(10, 1'b0, 1'b1, 1'b0, sa);
    run(12, 1'b0, 1'b0, 1'b0, sb);
    run(10, 1'b0, 1'b0, 1'b1, sa);
    run(12, 1'b0, 1'b0, 1'b0, sb);
    check("step_press_r_latency", sa.pr_first, 7);
    check("step_press_r_once", sa.pr_cnt + sb.pr_cnt, 1);
    check("step_en_cycle", sa.en_first, 8);
    check("step_en_once", sa.en_cnt + sb.en_cnt, 1);
`endif

    // Random button activity with occasional resets, checked every cycle.
    ru = 1'b0; rc = 1'b0; rs = 1'b0; hu = 0; hc = 0; hs = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hu == 0) begin ru = 1'($urandom_range(0, 1)); hu = int'($urandom_range(1, 12)); end
      if (hc == 0) begin rc = 1'($urandom_range(0, 1)); hc = int'($urandom_range(1, 14)); end
      if (hs == 0) begin rs = 1'($urandom_range(0, 1)); hs = int'($urandom_range(1, 12)); end
      hu--; hc--; hs--;
      rr = ($urandom_range(0, 299) == 0);
      tick(rr, ru, rc, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
